// File: rtl/dpram_port_arbiter.sv
// Two-requester arbiter in front of one port of a registered-read dual-port RAM.
// Optional ARB_ROUND_ROBIN_EN selects round-robin tie-break; default is fixed priority (req0 wins).
module dpram_port_arbiter #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              ram_wren,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data,
   input  logic [DATA_W-1:0] ram_q
);

   logic              r_ack0;
   logic              r_ack1;
   logic              r_rvalid0;
   logic              r_rvalid1;
   logic              r_wren;
   logic [ADDR_W-1:0] r_address;
   logic [DATA_W-1:0] r_data;
   logic              r_last_grant;

   logic              w_elig0;
   logic              w_elig1;
   logic              w_tie_to1;
   logic              w_gnt0;
   logic              w_gnt1;

   // A requester whose ack is high still holds req for the accepted access; mask it.
   always_comb begin
      w_elig0 = req0 & ~r_ack0;
      w_elig1 = req1 & ~r_ack1;
`ifdef ARB_ROUND_ROBIN_EN
      w_tie_to1 = ~r_last_grant;
`else
      w_tie_to1 = 1'b0;
`endif
      w_gnt0 = w_elig0 & ~(w_elig1 & w_tie_to1);
      w_gnt1 = w_elig1 & ~w_gnt0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ack0       <= 1'b0;
         r_ack1       <= 1'b0;
         r_rvalid0    <= 1'b0;
         r_rvalid1    <= 1'b0;
         r_wren       <= 1'b0;
         r_address    <= '0;
         r_data       <= '0;
         r_last_grant <= 1'b1;
      end else begin
         r_ack0    <= w_gnt0;
         r_ack1    <= w_gnt1;
         r_rvalid0 <= r_ack0;
         r_rvalid1 <= r_ack1;
         if (w_gnt0) begin
            r_wren       <= we0;
            r_address    <= addr0;
            r_data       <= wdata0;
            r_last_grant <= 1'b0;
         end else if (w_gnt1) begin
            r_wren       <= we1;
            r_address    <= addr1;
            r_data       <= wdata1;
            r_last_grant <= 1'b1;
         end else begin
            r_wren <= 1'b0;
         end
      end
   end

   assign ack0        = r_ack0;
   assign ack1        = r_ack1;
   assign rvalid0     = r_rvalid0;
   assign rvalid1     = r_rvalid1;
   assign rdata       = ram_q;
   assign ram_wren    = r_wren;
   assign ram_address = r_address;
   assign ram_data    = r_data;

endmodule
